siso_frame_rx: RTL and testbench

Serial frame receiver that sits directly downstream of the SISO shift register and consumes its `so` bit stream.
- Detects a start bit, then collects WIDTH data bits MSB-first.
- Presents the assembled word on a parallel bus with a valid/ready handshake.
- Flags frames lost while the output word is still unacknowledged.
- Single clock domain, same as the shift register feeding it.

---
 rtl/siso_frame_rx.sv | 113 +++++++++++
 tb/tb_siso_frame_rx.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/siso_frame_rx.sv
// Serial frame receiver: start bit, then WIDTH data bits MSB-first, presented on a valid/ready bus.
// Define SISO_RX_PARITY_EN to expect a trailing even-parity bit and report it on parity_err.
module siso_frame_rx #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rs,
    input  logic             si,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             overrun,
    output logic             parity_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] shift_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] dout_q;
    logic             dout_valid_q;
    logic             busy_q;
    logic             overrun_q;
    logic [WIDTH-1:0] shift_d;

    assign shift_d = {shift_q[WIDTH-2:0], si};

`ifdef SISO_RX_PARITY_EN
    logic parity_err_q;
`endif

    always_ff @(posedge clk or negedge rs) begin
        if (!rs) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            cnt_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef SISO_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (si) begin
                        state_q <= DATA;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                DATA: begin
                    shift_q <= shift_d;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BIT) begin
`ifdef SISO_RX_PARITY_EN
                        state_q <= PAR;
`else
                        dout_q       <= shift_d;
                        dout_valid_q <= 1'b1;
                        busy_q       <= 1'b0;
                        state_q      <= HOLD;
`endif
                    end
                end
`ifdef SISO_RX_PARITY_EN
                PAR: begin
                    // si is the parity bit; even parity means the XOR over data and parity is 0
                    dout_q       <= shift_q;
                    parity_err_q <= (^shift_q) ^ si;
                    dout_valid_q <= 1'b1;
                    busy_q       <= 1'b0;
                    state_q      <= HOLD;
                end
`endif
                HOLD: begin
                    if (dout_ready) begin
                        dout_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end else if (si) begin
                        overrun_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign busy       = busy_q;
    assign overrun    = overrun_q;
`ifdef SISO_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_siso_frame_rx.sv
// Bench for siso_frame_rx: directed scenarios plus random frames, checked by a queue-based scoreboard.
module tb_siso_frame_rx;

    localparam int W = 8;
`ifdef SISO_RX_PARITY_EN
    localparam int BUSY_CYC = W + 1;
`else
    localparam int BUSY_CYC = W;
`endif

    logic         clk;
    logic         rs;
    logic         si;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         dout_ready;
    logic         busy;
    logic         overrun;
    logic         parity_err;

    int           ready_mode;
    logic         rnd_ready;
    int           vectors;
    int           miscompares;

    typedef struct packed {
        logic         perr;
        logic [W-1:0] word;
    } exp_t;
    exp_t exp_q[$];

    siso_frame_rx #(.WIDTH(W), .CNT_W(6)) dut (
        .clk        (clk),
        .rs         (rs),
        .si         (si),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    assign dout_ready = (ready_mode == 2) ? rnd_ready : ready_mode[0];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) rnd_ready <= 1'($urandom_range(0, 1));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Scoreboard monitor: a handshake happens on the next rising edge whenever valid and ready are both high now
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rs && dout_valid && dout_ready) begin
                check("sb_word_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sb_dout", 32'(dout), 32'(e.word));
                    check("sb_parity_err", 32'(parity_err), 32'(e.perr));
                end
            end
        end
    end

    // Sends start + data MSB-first (+ parity). flip inverts the parity bit to provoke an error.
    task automatic send_frame(input logic [W-1:0] w, input logic flip, input bit push, input bit chk);
        logic bq[$];
        int   bcnt;
        logic prev_v;
        logic cur_v;
        exp_t e;
        bcnt   = 0;
        prev_v = 1'b0;
        cur_v  = 1'b0;
        bq.push_back(1'b1);
        for (int i = W - 1; i >= 0; i--) bq.push_back(w[i]);
`ifdef SISO_RX_PARITY_EN
        bq.push_back((^w) ^ flip);
        e.perr = flip;
`else
        e.perr = 1'b0;
`endif
        e.word = w;
        if (push) exp_q.push_back(e);
        for (int i = 0; i < bq.size(); i++) begin
            @(negedge clk);
            si = bq[i];
            #1;
            if (i > 0) bcnt += int'(busy);
            prev_v = cur_v;
            cur_v  = dout_valid;
        end
        @(negedge clk);
        si = 1'b0;
        #1;
        bcnt  += int'(busy);
        prev_v = cur_v;
        cur_v  = dout_valid;
        if (chk) begin
            check("busy_cycles", 32'(bcnt), 32'(BUSY_CYC));
            check("valid_before_last_edge", 32'(prev_v), 0);
            check("valid_after_last_edge", 32'(cur_v), 1);
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (dout_valid && t < 200) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("drain_timeout", 32'(dout_valid), 0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        ready_mode  = 0;
        rs          = 1'b0;
        si          = 1'b0;

        // Reset state and idle line
        repeat (2) @(negedge clk);
        #1;
        check("rst_dout", 32'(dout), 0);
        check("rst_valid", 32'(dout_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_parity_err", 32'(parity_err), 0);
        @(negedge clk);
        rs = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            si = 1'b0;
            #1;
            check("idle_valid", 32'(dout_valid), 0);
            check("idle_busy", 32'(busy), 0);
            check("idle_dout", 32'(dout), 0);
        end

        // Single frame with ready high
        ready_mode = 1;
        send_frame(8'hB2, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        #1;
        check("t2_valid_dropped", 32'(dout_valid), 0);
        check("t2_overrun", 32'(overrun), 0);
        check("t2_dout_kept", 32'(dout), 32'hB2);

        // Held word with ready low, then release and a follow-on frame
        ready_mode = 0;
        send_frame(8'hB2, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("t3_hold_dout", 32'(dout), 32'hB2);
            check("t3_hold_valid", 32'(dout_valid), 1);
        end
        @(negedge clk);
        ready_mode = 1;
        @(negedge clk);
        #1;
        check("t3_valid_after_hs", 32'(dout_valid), 0);
        send_frame(8'hF0, 1'b0, 1'b1, 1'b1);
        wait_drain();

        // Overrun: start bit while a word is held
        ready_mode = 0;
        send_frame(8'hB2, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        si = 1'b1;
        @(negedge clk);
        si = 1'b0;
        #1;
        check("t4_overrun_set", 32'(overrun), 1);
        check("t4_dout_held", 32'(dout), 32'hB2);
        ready_mode = 1;
        repeat (2) @(negedge clk);
        #1;
        check("t4_valid_after_hs", 32'(dout_valid), 0);
        check("t4_overrun_sticky", 32'(overrun), 1);
        @(posedge clk);
        #3;
        rs = 1'b0;
        #1;
        check("t4_overrun_cleared", 32'(overrun), 0);
        @(negedge clk);
        rs = 1'b1;

        // Asynchronous reset mid-frame, then a clean frame
        ready_mode = 1;
        begin
            logic [4:0] part;
            part = 5'b11010;
            for (int i = 4; i >= 0; i--) begin
                @(negedge clk);
                si = part[i];
            end
        end
        @(posedge clk);
        #3;
        rs = 1'b0;
        si = 1'b0;
        #1;
        check("t5_busy_async", 32'(busy), 0);
        check("t5_valid_async", 32'(dout_valid), 0);
        check("t5_dout_async", 32'(dout), 0);
        @(negedge clk);
        rs = 1'b1;
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
        wait_drain();

        // Parity good and bad (parity_err stays 0 in the default build)
        send_frame(8'hB2, 1'b0, 1'b1, 1'b1);
        wait_drain();
        send_frame(8'hB2, 1'b1, 1'b1, 1'b1);
        wait_drain();

        // Random frames, random ready, random gaps
        ready_mode = 2;
        for (int n = 0; n < 40; n++) begin
            logic [W-1:0] w;
            logic         f;
            int           gap;
            w   = W'($urandom);
            f   = 1'($urandom_range(0, 1));
            gap = int'($urandom_range(0, 3));
            send_frame(w, f, 1'b1, 1'b1);
            wait_drain();
            repeat (gap) begin
                @(negedge clk);
                si = 1'b0;
            end
        end

        repeat (4) @(negedge clk);
        #2;
        check("sb_all_consumed", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
